// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
//   state_e : arbiter FSM states
//   port_e  : requester index (core = 0, debug/loader = 1)
//   RD_LAT_MIN/MAX : legal range of the fixed read latency
//   CNT_W   : width of the read-latency counter (covers RD_LAT_MAX)
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/arb_rr2.sv
// Two-request round-robin selector, purely combinational.
//   req_i  : request vector, bit 0 = core, bit 1 = debug
//   last_i : port granted most recently
//   gnt_o  : one-hot grant (or zero when nobody requests)
// A lone requester always wins; on a conflict the port that was not
// granted last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_e      last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_CORE) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a core port and a debug/loader port onto one memory/IO port.
//   clk_i, rst_ni            : clock, async active-low reset
//   c_* / d_*                : requester ports (req, we, addr, func3, wdata in;
//                              gnt, rvalid, rdata out)
//   m_req_o .. m_wdata_o     : memory-side strobe and payload
//   m_rdata_i                : memory read data, valid RD_LAT cycles after strobe
// Writes issue in one cycle and keep the FSM in IDLE. A read parks the FSM in
// RD_WAIT for RD_LAT cycles; the data is registered into the owner's rdata_o
// and rvalid_o pulses in the following cycle, which is already IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [2:0]        c_func3_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [DATA_W-1:0] c_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [2:0]        d_func3_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [2:0]        m_func3_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("mem_arbiter: RD_LAT must be within 1..7");
  end

  state_e                   state_q, state_d;
  port_e                    ptr_q, owner_q, win;
  logic [CNT_W-1:0]         cnt_q;
  logic [1:0]               arb_gnt, gnt;
  logic [1:0]               rvalid_q;
  logic [1:0][DATA_W-1:0]   rdata_q;
  logic                     rd_issue, rd_done;

  arb_rr2 u_rr (
    .req_i  ({d_req_i, c_req_i}),
    .last_i (ptr_q),
    .gnt_o  (arb_gnt)
  );

  // Grants only exist in IDLE; reset gating keeps them low while rst_ni is
  // held even though requesters may still be driving req.
  assign gnt      = (state_q == IDLE && rst_ni) ? arb_gnt : 2'b00;
  assign win      = gnt[1] ? PORT_DBG : PORT_CORE;
  assign rd_issue = (|gnt) && !m_we_o;
  // Counter holds RD_LAT in the first wait cycle, so 1 marks the data cycle.
  assign rd_done  = (state_q == RD_WAIT) && (cnt_q == CNT_W'(1));

  // Memory-side mux; payload is forced to zero when nothing is granted.
  always_comb begin
    m_req_o   = |gnt;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_func3_o = '0;
    m_wdata_o = '0;
    if (gnt[0]) begin
      m_we_o    = c_we_i;
      m_addr_o  = c_addr_i;
      m_func3_o = c_func3_i;
      m_wdata_o = c_wdata_i;
    end else if (gnt[1]) begin
      m_we_o    = d_we_i;
      m_addr_o  = d_addr_i;
      m_func3_o = d_func3_i;
      m_wdata_o = d_wdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_issue) state_d = RD_WAIT;
      RD_WAIT: if (rd_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= PORT_DBG;
      owner_q  <= PORT_CORE;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= '0;
      if (|gnt) ptr_q <= win;
      if (rd_issue) begin
        cnt_q   <= CNT_W'(RD_LAT);
        owner_q <= win;
      end else if (state_q == RD_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (rd_done) begin
        rvalid_q[owner_q] <= 1'b1;
        rdata_q[owner_q]  <= m_rdata_i;
      end
    end
  end

  assign c_gnt_o    = gnt[0];
  assign d_gnt_o    = gnt[1];
  assign c_rvalid_o = rvalid_q[0];
  assign d_rvalid_o = rvalid_q[1];
  assign c_rdata_o  = rdata_q[0];
  assign d_rdata_o  = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share all inputs:
// index 0 has RD_LAT=1, index 1 has RD_LAT=3. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [11:0] c_addr, d_addr;
  logic [2:0]  c_func3, d_func3;
  logic [31:0] c_wdata, d_wdata, m_rdata;

  logic        c_gnt [2];
  logic        c_rvalid [2];
  logic [31:0] c_rdata [2];
  logic        d_gnt [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata [2];
  logic        m_req [2];
  logic        m_we [2];
  logic [11:0] m_addr [2];
  logic [2:0]  m_func3 [2];
  logic [31:0] m_wdata [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_func3_i(c_func3),
      .c_wdata_i(c_wdata), .c_gnt_o(c_gnt[g]), .c_rvalid_o(c_rvalid[g]),
      .c_rdata_o(c_rdata[g]),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_func3_i(d_func3),
      .d_wdata_i(d_wdata), .d_gnt_o(d_gnt[g]), .d_rvalid_o(d_rvalid[g]),
      .d_rdata_o(d_rdata[g]),
      .m_req_o(m_req[g]), .m_we_o(m_we[g]), .m_addr_o(m_addr[g]),
      .m_func3_o(m_func3[g]), .m_wdata_o(m_wdata[g]), .m_rdata_i(m_rdata)
    );
  end

  // Continuous invariants on both instances.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (c_gnt[g] && d_gnt[g]) begin
        errors++; $display("FAIL inv_gnt_onehot[%0d]: got c=%b d=%b, need at most one", g, c_gnt[g], d_gnt[g]);
      end
      checks++;
      if (c_rvalid[g] && d_rvalid[g]) begin
        errors++; $display("FAIL inv_rvalid_onehot[%0d]: got c=%b d=%b, need at most one", g, c_rvalid[g], d_rvalid[g]);
      end
      checks++;
      if (m_req[g] !== (c_gnt[g] | d_gnt[g])) begin
        errors++; $display("FAIL inv_mreq[%0d]: got %b need %b", g, m_req[g], c_gnt[g] | d_gnt[g]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_func3 = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_func3 = 0; d_wdata = 0;
    m_rdata = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    c_req = 1; d_req = 1;
    #2;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (c_gnt[g] !== 1'b0 || d_gnt[g] !== 1'b0) begin
        errors++; $display("FAIL reset_gnt[%0d]: got c=%b d=%b need 0", g, c_gnt[g], d_gnt[g]);
      end
      checks++;
      if (m_req[g] !== 1'b0 || m_we[g] !== 1'b0) begin
        errors++; $display("FAIL reset_mreq[%0d]: got req=%b we=%b need 0", g, m_req[g], m_we[g]);
      end
      checks++;
      if (c_rvalid[g] !== 1'b0 || d_rvalid[g] !== 1'b0) begin
        errors++; $display("FAIL reset_rvalid[%0d]: got c=%b d=%b need 0", g, c_rvalid[g], d_rvalid[g]);
      end
      checks++;
      if (c_rdata[g] !== 32'h0 || d_rdata[g] !== 32'h0) begin
        errors++; $display("FAIL reset_rdata[%0d]: got c=%h d=%h need 0", g, c_rdata[g], d_rdata[g]);
      end
    end
    clear_inputs();
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_idle();
    clear_inputs();
    c_addr = 12'h0AB; c_wdata = 32'hFFFF0000; d_addr = 12'h0CD; d_wdata = 32'h0000FFFF;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (m_req[g] !== 1'b0 || m_we[g] !== 1'b0) begin
        errors++; $display("FAIL idle_mreq[%0d]: got req=%b we=%b need 0", g, m_req[g], m_we[g]);
      end
      checks++;
      if (m_addr[g] !== 12'h0 || m_wdata[g] !== 32'h0 || m_func3[g] !== 3'h0) begin
        errors++; $display("FAIL idle_payload[%0d]: got addr=%h wdata=%h f3=%h need 0", g, m_addr[g], m_wdata[g], m_func3[g]);
      end
    end
    cyc();
    clear_inputs();
  endtask

  // Instance 0, RD_LAT=1: grant in cycle 0, rvalid in cycle 2 only.
  task automatic test_core_read();
    apply_reset();
    c_req = 1; c_we = 0; c_addr = 12'h040; c_func3 = 3'b010;
    @(negedge clk);
    checks++;
    if (c_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0) begin
      errors++; $display("FAIL cr_gnt: got c=%b d=%b need c=1 d=0", c_gnt[0], d_gnt[0]);
    end
    checks++;
    if (m_addr[0] !== 12'h040 || m_we[0] !== 1'b0 || m_func3[0] !== 3'b010) begin
      errors++; $display("FAIL cr_payload: got addr=%h we=%b f3=%b need 040/0/010", m_addr[0], m_we[0], m_func3[0]);
    end
    cyc();
    c_req = 0; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (c_rvalid[0] !== 1'b0 || m_req[0] !== 1'b0) begin
      errors++; $display("FAIL cr_cyc1: got rvalid=%b mreq=%b need 0/0", c_rvalid[0], m_req[0]);
    end
    cyc();
    m_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (c_rvalid[0] !== 1'b1 || c_rdata[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cr_cyc2: got rvalid=%b rdata=%h need 1/deadbeef", c_rvalid[0], c_rdata[0]);
    end
    checks++;
    if (d_rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL cr_d_rvalid: got %b need 0", d_rvalid[0]);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (c_rvalid[0] !== 1'b0 || c_rdata[0] !== 32'hDEADBEEF || d_rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL cr_cyc3: got rvalid=%b rdata=%h d_rvalid=%b need 0/deadbeef/0", c_rvalid[0], c_rdata[0], d_rvalid[0]);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_core;
    exp_core = 4'b0101;   // bit k: core expected to win in cycle k
    apply_reset();
    c_req = 1; c_we = 1; c_addr = 12'h100; c_func3 = 3'b010; c_wdata = 32'hAAAA0001;
    d_req = 1; d_we = 1; d_addr = 12'h200; d_func3 = 3'b010; d_wdata = 32'hBBBB0002;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (c_gnt[g] !== exp_core[k] || d_gnt[g] !== !exp_core[k]) begin
          errors++; $display("FAIL b2b_gnt[%0d] cyc%0d: got c=%b d=%b need c=%b", g, k, c_gnt[g], d_gnt[g], exp_core[k]);
        end
        checks++;
        if (m_req[g] !== 1'b1 || m_we[g] !== 1'b1) begin
          errors++; $display("FAIL b2b_mreq[%0d] cyc%0d: got req=%b we=%b need 1/1", g, k, m_req[g], m_we[g]);
        end
        checks++;
        if (m_addr[g] !== (exp_core[k] ? 12'h100 : 12'h200) ||
            m_wdata[g] !== (exp_core[k] ? 32'hAAAA0001 : 32'hBBBB0002)) begin
          errors++; $display("FAIL b2b_payload[%0d] cyc%0d: got addr=%h wdata=%h", g, k, m_addr[g], m_wdata[g]);
        end
      end
      cyc();
    end
    clear_inputs();
  endtask

  // Instance 1, RD_LAT=3: core read first, debug read granted in the core's
  // rvalid cycle, each rvalid 4 cycles after its grant.
  task automatic test_dbg_core_reads();
    apply_reset();
    c_req = 1; c_we = 0; c_addr = 12'h010; c_func3 = 3'b010;
    d_req = 1; d_we = 0; d_addr = 12'h7F0; d_func3 = 3'b010;
    @(negedge clk);
    checks++;
    if (c_gnt[1] !== 1'b1 || d_gnt[1] !== 1'b0 || m_addr[1] !== 12'h010) begin
      errors++; $display("FAIL dc_first: got c=%b d=%b addr=%h need 1/0/010", c_gnt[1], d_gnt[1], m_addr[1]);
    end
    cyc();
    c_req = 0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) m_rdata = 32'hC0C00001;
      @(negedge clk);
      checks++;
      if (d_gnt[1] !== 1'b0 || m_req[1] !== 1'b0 || c_rvalid[1] !== 1'b0) begin
        errors++; $display("FAIL dc_wait1 cyc%0d: got dgnt=%b mreq=%b rvalid=%b need 0", k, d_gnt[1], m_req[1], c_rvalid[1]);
      end
      cyc();
    end
    m_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (c_rvalid[1] !== 1'b1 || c_rdata[1] !== 32'hC0C00001) begin
      errors++; $display("FAIL dc_core_rvalid: got %b/%h need 1/c0c00001", c_rvalid[1], c_rdata[1]);
    end
    checks++;
    if (d_gnt[1] !== 1'b1 || m_addr[1] !== 12'h7F0 || d_rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL dc_dbg_gnt: got gnt=%b addr=%h drv=%b need 1/7f0/0", d_gnt[1], m_addr[1], d_rvalid[1]);
    end
    cyc();
    d_req = 0;
    for (int k = 5; k <= 7; k++) begin
      if (k == 7) m_rdata = 32'hD0D00002;
      @(negedge clk);
      checks++;
      if (d_rvalid[1] !== 1'b0 || m_req[1] !== 1'b0) begin
        errors++; $display("FAIL dc_wait2 cyc%0d: got rvalid=%b mreq=%b need 0", k, d_rvalid[1], m_req[1]);
      end
      cyc();
    end
    m_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 32'hD0D00002 || c_rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL dc_dbg_rvalid: got %b/%h crv=%b need 1/d0d00002/0", d_rvalid[1], d_rdata[1], c_rvalid[1]);
    end
    checks++;
    if (c_rdata[1] !== 32'hC0C00001) begin
      errors++; $display("FAIL dc_core_hold: got %h need c0c00001", c_rdata[1]);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (d_rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL dc_pulse_len: got %b need 0", d_rvalid[1]);
    end
    cyc();
  endtask

  // Instance 1 still holds c_rdata = c0c00001 from the previous test.
  task automatic test_reset_mid_read();
    c_req = 1; c_we = 0; c_addr = 12'h030; c_func3 = 3'b010;
    @(negedge clk);
    checks++;
    if (c_gnt[1] !== 1'b1) begin
      errors++; $display("FAIL rm_gnt: got %b need 1", c_gnt[1]);
    end
    cyc();
    c_req = 0; m_rdata = 32'h55AA55AA;
    rst_n = 0;
    #1;
    checks++;
    if (c_gnt[1] !== 1'b0 || d_gnt[1] !== 1'b0 || m_req[1] !== 1'b0 || m_we[1] !== 1'b0) begin
      errors++; $display("FAIL rm_async_gnt: got c=%b d=%b mreq=%b we=%b need 0", c_gnt[1], d_gnt[1], m_req[1], m_we[1]);
    end
    checks++;
    if (c_rdata[1] !== 32'h0 || c_rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL rm_async_data: got rdata=%h rvalid=%b need 0/0", c_rdata[1], c_rvalid[1]);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (c_rvalid[1] !== 1'b0) begin
        errors++; $display("FAIL rm_no_rvalid cyc%0d: got %b need 0", k, c_rvalid[1]);
      end
      cyc();
    end
    c_req = 1; c_we = 1; c_addr = 12'h111;
    d_req = 1; d_we = 1; d_addr = 12'h222;
    @(negedge clk);
    checks++;
    if (c_gnt[1] !== 1'b1 || d_gnt[1] !== 1'b0) begin
      errors++; $display("FAIL rm_conflict: got c=%b d=%b need c=1 d=0", c_gnt[1], d_gnt[1]);
    end
    cyc();
    clear_inputs();
  endtask

  // Instance 0, RD_LAT=1: write presented during RD_WAIT, granted in rvalid cycle.
  task automatic test_write_in_rvalid();
    apply_reset();
    c_req = 1; c_we = 0; c_addr = 12'h020; c_func3 = 3'b010;
    @(negedge clk);
    checks++;
    if (c_gnt[0] !== 1'b1) begin
      errors++; $display("FAIL wr_rd_gnt: got %b need 1", c_gnt[0]);
    end
    cyc();
    c_we = 1; c_addr = 12'h7A0; c_func3 = 3'b010; c_wdata = 32'h12345678;
    m_rdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (c_gnt[0] !== 1'b0 || m_req[0] !== 1'b0) begin
      errors++; $display("FAIL wr_wait: got gnt=%b mreq=%b need 0/0", c_gnt[0], m_req[0]);
    end
    cyc();
    m_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (c_rvalid[0] !== 1'b1 || c_rdata[0] !== 32'h0BADF00D) begin
      errors++; $display("FAIL wr_rvalid: got %b/%h need 1/0badf00d", c_rvalid[0], c_rdata[0]);
    end
    checks++;
    if (c_gnt[0] !== 1'b1 || m_we[0] !== 1'b1 || m_wdata[0] !== 32'h12345678) begin
      errors++; $display("FAIL wr_grant: got gnt=%b we=%b wdata=%h need 1/1/12345678", c_gnt[0], m_we[0], m_wdata[0]);
    end
    checks++;
    if (m_addr[0] !== 12'h7A0 || m_func3[0] !== 3'b010) begin
      errors++; $display("FAIL wr_addr: got addr=%h f3=%b need 7a0/010", m_addr[0], m_func3[0]);
    end
    cyc();
    c_req = 0;
    @(negedge clk);
    checks++;
    if (c_rvalid[0] !== 1'b0 || m_req[0] !== 1'b0) begin
      errors++; $display("FAIL wr_after: got rvalid=%b mreq=%b need 0/0", c_rvalid[0], m_req[0]);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_core_read();
    test_back_to_back();
    test_dbg_core_reads();
    test_reset_mid_read();
    test_write_in_rvalid();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, byte address width of the shared data-memory/IO port.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter RD_LAT, default 1 (legal 1..7), fixed cycles from read issue to m_rdata_i valid.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 c_req_i / c_we_i  input  1 / 1  core port request; write when 1, read when 0.
REQ-007 c_addr_i / c_func3_i / c_wdata_i  input  ADDR_W / 3 / DATA_W  core address, access size (RISC-V funct3), store data.
REQ-008 c_gnt_o / c_rvalid_o / c_rdata_o  output  1 / 1 / DATA_W  core grant, read-data valid pulse, read data.
REQ-009 d_req_i, d_we_i, d_addr_i, d_func3_i, d_wdata_i, d_gnt_o, d_rvalid_o, d_rdata_o  same widths and meanings as the core port, for the debug/loader port.
REQ-010 m_req_o / m_we_o  output  1 / 1  memory-side access strobe and write enable.
REQ-011 m_addr_o / m_func3_o / m_wdata_o  output  ADDR_W / 3 / DATA_W  memory-side address, size, store data.
REQ-012 m_rdata_i  input  DATA_W  memory-side read data, valid RD_LAT cycles after the read strobe.

Function
REQ-013 FSM states: IDLE and RD_WAIT.
REQ-014 In IDLE with at least one req high, the block SHALL select one winner in the same cycle (combinational), assert that port's gnt_o and m_req_o, and drive m_we_o/m_addr_o/m_func3_o/m_wdata_o from the winner's inputs.
REQ-015 Arbitration: round-robin on a 1-bit last-grant pointer. On conflict, the port not granted last wins. Pointer updates on every grant.
REQ-016 Single request: that port wins regardless of the pointer.
REQ-017 Requester holds req and payload stable until it sees gnt_o high. A request dropped before grant is never issued.
REQ-018 Write grant: FSM stays in IDLE, so back-to-back writes issue every cycle. No rvalid is produced for a write.
REQ-019 Read grant: FSM enters RD_WAIT, loads a latency counter with RD_LAT and records the owner.
REQ-020 In RD_WAIT: no gnt_o, m_req_o = 0; the counter decrements each cycle.
REQ-021 When the counter reaches its end, the block SHALL capture m_rdata_i into the owner's rdata_o and pulse the owner's rvalid_o for exactly one cycle, RD_LAT+1 cycles after the grant cycle, then return to IDLE.
REQ-022 A new grant may occur in the cycle rvalid_o is high, as that cycle is already IDLE.
REQ-023 rdata_o of each port holds its last captured value until the next read for that port.
REQ-024 Never both gnt_o high; never both rvalid_o high; m_req_o = c_gnt_o | d_gnt_o.
REQ-025 With both ports requesting continuously, neither port waits more than one grant.
REQ-026 With no request, m_req_o = 0 and m_* payload = 0.

Reset
REQ-027 rst_ni low SHALL asynchronously force: FSM = IDLE, pointer = "debug last" (core wins the first conflict), counter = 0, all gnt_o/rvalid_o/m_req_o/m_we_o = 0, all rdata_o = 0.
REQ-028 Reset during RD_WAIT SHALL abandon the read; no rvalid_o is emitted after reset release.

Structure
REQ-029 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, RD_WAIT), the port-index type (PORT_CORE = 0, PORT_DBG = 1) and the RD_LAT legal-range constants.
REQ-030 The round-robin selector SHALL be one sub-module, arb_rr2 (2 requests + pointer in, one-hot grant out, combinational). The FSM, counter and data capture SHALL stay in mem_arbiter.

Verification
REQ-031 Core-only read, RD_LAT=1, c_addr_i=0x040, m_rdata_i=0xDEADBEEF: c_gnt_o in cycle 0, c_rvalid_o=1 with c_rdata_o=0xDEADBEEF in cycle 2 only; d_rvalid_o stays 0.
REQ-032 Both ports request writes every cycle for 4 cycles after reset: grants alternate core, debug, core, debug; m_req_o=1 every cycle.
REQ-033 Debug read 0x7F0 then core read 0x010 requested together, RD_LAT=3: debug served second (core wins first); each rvalid lands 4 cycles after its grant; no grant is issued during RD_WAIT.
REQ-034 rst_ni asserted for 1 cycle, 1 cycle after a core read grant with RD_LAT=3: all outputs go 0 immediately; no c_rvalid_o follows; the next conflict is won by core.
REQ-035 Core write (c_func3_i=3'b010, c_wdata_i=0x12345678, addr 0x7A0) is granted in the cycle a prior read's rvalid pulses: m_we_o=1 and m_wdata_o=0x12345678 in that same cycle.
REQ-036 Bench assertions throughout: grants one-hot-or-zero; rvalid one-hot-or-zero; m_req_o low in RD_WAIT.
